// File: rtl/binary_counter_param_sync_pkg.sv
// Shared counter-family definitions: count direction codes and the
// effective-modulus rule used by every counter variant.
package binary_counter_param_sync_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // MODULUS = 0 selects the full binary range of the counter.
    function automatic logic [32:0] eff_modulus(
        input int unsigned     width,
        input longint unsigned modulus
    );
        if (modulus == 0)
            return 33'd1 << width;
        else
            return modulus[32:0];
    endfunction

    function automatic bit modulus_ok(
        input int unsigned     width,
        input longint unsigned modulus
    );
        return (modulus == 0) ||
               (modulus >= 2 && modulus <= (64'd1 << width));
    endfunction

endpackage

// File: rtl/binary_counter_param_sync_if.sv
// Control and status bundle between the counter and its consumer.
interface binary_counter_param_sync_if #(
    parameter int unsigned WIDTH = 4
) ();

    logic             enable;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tick;
    logic             terminal_count;
    logic             wrap;

    modport master (
        output enable, up_down, load, load_value,
        input  q, qbar, tick, terminal_count, wrap
    );

    modport slave (
        input  enable, up_down, load, load_value,
        output q, qbar, tick, terminal_count, wrap
    );

endinterface

// File: rtl/binary_counter_param_sync_prescaler.sv
// Clock-enable prescaler: strobes tick once every PRESCALE enabled clocks.
module clock_enable_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    logic [PW-1:0] p_q;
    logic [PW-1:0] p_d;
    logic          last;

    assign last = (p_q == PLAST);
    assign tick = enable & last & ~reset;

    always_comb begin
        p_d = p_q;
        if (clear)
            p_d = '0;
        else if (enable)
            p_d = last ? '0 : p_q + PW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)
            p_q <= '0;
        else
            p_q <= p_d;
    end

endmodule

// File: rtl/binary_counter_param_sync.sv
// Synchronous up/down modulo-M counter with load, prescaler and wrap pulse.
module binary_counter_param_sync
    import binary_counter_param_sync_pkg::*;
#(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 0,
    parameter int unsigned     PRESCALE = 1
) (
    input logic                        clock,
    input logic                        reset,
    binary_counter_param_sync_if.slave bus
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("binary_counter_param_sync: WIDTH %0d outside 1..32", WIDTH);
    end
    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("binary_counter_param_sync: illegal MODULUS %0d", MODULUS);
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("binary_counter_param_sync: PRESCALE %0d outside 1..65535",
               PRESCALE);
    end

    localparam logic [32:0]      M    = eff_modulus(WIDTH, MODULUS);
    localparam logic [32:0]      M1   = M - 33'd1;
    localparam logic [WIDTH-1:0] MAXV = M1[WIDTH-1:0];

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             tick;
    logic [WIDTH-1:0] load_clamped;

    clock_enable_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (bus.enable),
        .clear  (bus.load),
        .tick   (tick)
    );

    // Out-of-range presets saturate to the top of the count range.
    assign load_clamped = (33'(bus.load_value) >= M) ? MAXV : bus.load_value;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            q_d = load_clamped;
        end else if (tick) begin
            if (bus.up_down == DIR_UP) begin
                if (q_q == MAXV) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (q_q == '0) begin
                    q_d    = MAXV;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.q              = q_q;
    assign bus.qbar           = ~q_q;
    assign bus.wrap           = wrap_q;
    assign bus.tick           = tick;
    assign bus.terminal_count = (bus.up_down == DIR_UP) ? (q_q == MAXV)
                                                        : (q_q == '0);

endmodule
